// File: rtl/imem_port.sv
// Instruction-memory fetch port: a PC-driven single-outstanding read master feeding
// a 2-entry prefetch FIFO, with redirect handling that drains an in-flight read.
module imem_port #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        i_hold,
    input  logic        i_jmp,
    input  logic [15:0] i_jmp_addr,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        o_rdy,
    output logic [15:0] o_data
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DROP = 1'b1
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] pend_addr;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [15:0] fifo_mem [2];

    logic ack_seen;
    logic push;
    logic pop;

    // NOTE: every signal in this block is assigned on every path, so no latch can be inferred.
    always_comb begin
        // Gated by reset so the request drops the instant reset asserts.
        mem_req  = a_rst & ((state == ST_DROP) | (count < 2'd2));
        ack_seen = mem_req & mem_ack;
        push     = ack_seen & (state == ST_RUN) & ~i_jmp;
        o_rdy    = (count != 2'd0);
        pop      = o_rdy & ~i_hold;
        o_data   = fifo_mem[rd_ptr];
    end

    assign mem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state     <= ST_RUN;
            pc        <= RESET_PC;
            pend_addr <= 16'h0000;
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_jmp) begin
                        // A read still in flight must complete before the PC can move.
                        if (mem_req & ~mem_ack) begin
                            pend_addr <= i_jmp_addr;
                            state     <= ST_DROP;
                        end else begin
                            pc <= i_jmp_addr;
                        end
                    end else if (push) begin
                        pc <= pc + 16'd1;
                    end
                end
                ST_DROP: begin
                    if (i_jmp) begin
                        pend_addr <= i_jmp_addr;
                    end
                    if (ack_seen) begin
                        pc    <= i_jmp ? i_jmp_addr : pend_addr;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (i_jmp) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the word storage has no reset; its contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_data;
        end
    end

endmodule
